// File: rtl/net_ctrl_pkg.sv
// Shared network-control definitions: sequencer state encodings and the
// default layer count / layer index width used by the RAM controller and datapath.
package net_ctrl_pkg;

    localparam int unsigned NUM_LAYERS_DEF = 3;
    localparam int unsigned LAYER_W_DEF    = 2;
    localparam int unsigned STATE_W        = 3;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LAUNCH  = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_ADVANCE = 3'd3;
    localparam logic [2:0] ST_FINISH  = 3'd4;

endpackage

// File: rtl/layer_sequencer_if.sv
// Control/status bundle between the top-level start/abort logic, the
// RAM controller and the layer sequencer. The sequencer uses the slave view.
interface layer_sequencer_if #(
    parameter int unsigned LAYER_W = net_ctrl_pkg::LAYER_W_DEF
);
    logic               start;
    logic               done;
    logic               abort;
    logic [LAYER_W-1:0] layer;
    logic               layer_sel;
    logic               ram_start;
    logic               busy;
    logic               net_done;
    logic               timeout;

    modport master (
        output start, done, abort,
        input  layer, layer_sel, ram_start, busy, net_done, timeout
    );

    modport slave (
        input  start, done, abort,
        output layer, layer_sel, ram_start, busy, net_done, timeout
    );
endinterface

// File: rtl/layer_watchdog.sv
// Per-layer WAIT watchdog: counts cycles while enabled, flags expiry when the
// count reaches TIMEOUT_CYCLES-1. Instantiated only with LAYER_SEQUENCER_WATCHDOG_EN.
module layer_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;

    // Cycle counter, held at zero outside WAIT so each layer starts fresh
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign expire = (count_q == LIMIT);
endmodule

// File: rtl/layer_sequencer.sv
// Network-level layer sequencer: steps layer 0..NUM_LAYERS-1, launches the
// RAM controller per layer, waits for done, and flags end of pass.
// Optional watchdog: define LAYER_SEQUENCER_WATCHDOG_EN.
module layer_sequencer
    import net_ctrl_pkg::*;
#(
    parameter int unsigned NUM_LAYERS     = NUM_LAYERS_DEF,
    parameter int unsigned LAYER_W        = LAYER_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic               clk,
    input logic               reset,
    layer_sequencer_if.slave  bus
);
    localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [LAYER_W-1:0] layer_q, layer_d;
    logic               timeout_d;
    logic               expire;

    logic ram_start_q, busy_q, net_done_q, layer_sel_q, timeout_q;

`ifdef LAYER_SEQUENCER_WATCHDOG_EN
    logic wd_clear;
    logic wd_enable;

    assign wd_clear  = (state_q != ST_WAIT);
    assign wd_enable = (state_q == ST_WAIT) && !bus.done;

    layer_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

    // State and layer index registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            layer_q <= '0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
        end
    end

    // Next-state / next-layer logic; abort overrides everything
    always_comb begin
        state_d   = state_q;
        layer_d   = layer_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                layer_d = '0;
                if (bus.start) begin
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.done) begin
                    state_d = ST_ADVANCE;
                end else if (expire) begin
                    state_d   = ST_IDLE;
                    layer_d   = '0;
                    timeout_d = 1'b1;
                end
            end
            ST_ADVANCE: begin
                if (layer_q == LAST_LAYER) begin
                    state_d = ST_FINISH;
                end else begin
                    layer_d = layer_q + LAYER_W'(1);
                    state_d = ST_LAUNCH;
                end
            end
            ST_FINISH: begin
                layer_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                layer_d = '0;
            end
        endcase
        if (bus.abort) begin
            state_d   = ST_IDLE;
            layer_d   = '0;
            timeout_d = 1'b0;
        end
    end

    // Outputs registered from the next state so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_start_q <= 1'b0;
            busy_q      <= 1'b0;
            net_done_q  <= 1'b0;
            layer_sel_q <= (NUM_LAYERS > 1);
            timeout_q   <= 1'b0;
        end else begin
            ram_start_q <= (state_d == ST_LAUNCH);
            busy_q      <= (state_d != ST_IDLE);
            net_done_q  <= (state_d == ST_FINISH);
            layer_sel_q <= (layer_d != LAST_LAYER);
            timeout_q   <= timeout_d;
        end
    end

    assign bus.layer     = layer_q;
    assign bus.layer_sel = layer_sel_q;
    assign bus.ram_start = ram_start_q;
    assign bus.busy      = busy_q;
    assign bus.net_done  = net_done_q;
    assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer (3-layer and 1-layer instances).
module tb_layer_sequencer;
    localparam int unsigned NL = 3;
    localparam int unsigned LW = 2;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    layer_sequencer_if #(.LAYER_W(LW)) a_if ();
    layer_sequencer_if #(.LAYER_W(1))  b_if ();

    layer_sequencer #(.NUM_LAYERS(NL), .LAYER_W(LW), .TIMEOUT_CYCLES(TO)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if.slave)
    );

    layer_sequencer #(.NUM_LAYERS(1), .LAYER_W(1), .TIMEOUT_CYCLES(TO)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if.slave)
    );

    int vectors      = 0;
    int miscompares  = 0;
    int exp_launches = 0;
    int exp_dones    = 0;
    int rs_seen      = 0;
    int nd_seen      = 0;

    // Scoreboard monitor: count pulses seen on the 3-layer instance
    always @(negedge clk) begin
        if (a_if.ram_start === 1'b1) rs_seen++;
        if (a_if.net_done === 1'b1) nd_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Packed outputs {ram_start, layer, layer_sel, busy, net_done, timeout}
    task automatic chk_a(input string tag, input bit rs, input int lay, input bit bsy,
                         input bit nd, input bit to);
        logic [6:0] got;
        logic [6:0] exp;
        got = {a_if.ram_start, a_if.layer, a_if.layer_sel, a_if.busy, a_if.net_done, a_if.timeout};
        exp = {rs, LW'(lay), (lay != int'(NL) - 1), bsy, nd, to};
        chk(tag, 32'(got), 32'(exp));
    endtask

    task automatic chk_b(input string tag, input bit rs, input bit bsy, input bit nd);
        logic [5:0] got;
        logic [5:0] exp;
        got = {b_if.ram_start, b_if.layer, b_if.layer_sel, b_if.busy, b_if.net_done, b_if.timeout};
        exp = {rs, 1'b0, 1'b0, bsy, nd, 1'b0};
        chk(tag, 32'(got), 32'(exp));
    endtask

    // Called in the LAUNCH cycle of layer i; ends in the next LAUNCH or in IDLE after FINISH
    task automatic run_layer(input int i, input int lat);
        chk_a("launch", 1'b1, i, 1'b1, 1'b0, 1'b0);
        a_if.done = 1'($urandom_range(0, 1));
        tick();
        a_if.done = 1'b0;
        for (int k = 0; k < lat; k++) begin
            chk_a("wait", 1'b0, i, 1'b1, 1'b0, 1'b0);
            tick();
        end
        a_if.done = 1'b1;
        chk_a("wait_done", 1'b0, i, 1'b1, 1'b0, 1'b0);
        tick();
        a_if.done = 1'b0;
        chk_a("advance", 1'b0, i, 1'b1, 1'b0, 1'b0);
        tick();
        if (i == int'(NL) - 1) begin
            chk_a("finish", 1'b0, i, 1'b1, 1'b1, 1'b0);
            exp_dones++;
            tick();
            chk_a("idle_after_pass", 1'b0, 0, 1'b0, 1'b0, 1'b0);
        end else begin
            exp_launches++;
        end
    endtask

    task automatic run_pass(input bit hold, input int fixed_lat);
        int base;
        base = rs_seen;
        a_if.start = 1'b1;
        tick();
        if (!hold) a_if.start = 1'b0;
        exp_launches++;
        for (int i = 0; i < int'(NL); i++) begin
            run_layer(i, (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 7)));
        end
        chk("launches_per_pass", 32'(rs_seen - base), 32'(NL));
    endtask

    initial begin
        int nd_before;
        reset      = 1'b1;
        a_if.start = 1'b0; a_if.done = 1'b0; a_if.abort = 1'b0;
        b_if.start = 1'b0; b_if.done = 1'b0; b_if.abort = 1'b0;
        tick();
        tick();
        chk_a("reset_a", 1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk_b("reset_b", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        chk_a("idle_a", 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // Nominal pass, done 5 cycles after each ram_start
        run_pass(1'b0, 4);

        // Randomised done latencies
        for (int p = 0; p < 4; p++) begin
            tick();
            run_pass(1'b0, -1);
        end

        // Start held high: one pass, then relaunch only after returning to IDLE
        tick();
        run_pass(1'b1, -1);
        tick();
        a_if.start = 1'b0;
        exp_launches++;
        chk_a("relaunch_after_idle", 1'b1, 0, 1'b1, 1'b0, 1'b0);
        a_if.abort = 1'b1;
        tick();
        a_if.abort = 1'b0;
        chk_a("abort_in_wait0", 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // Abort during WAIT of layer 1, stray done 2 cycles later
        tick();
        nd_before  = nd_seen;
        a_if.start = 1'b1;
        tick();
        a_if.start = 1'b0;
        exp_launches++;
        run_layer(0, 2);
        chk_a("launch_l1", 1'b1, 1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_a("wait_l1", 1'b0, 1, 1'b1, 1'b0, 1'b0);
        tick();
        a_if.abort = 1'b1;
        tick();
        a_if.abort = 1'b0;
        chk_a("abort_to_idle", 1'b0, 0, 1'b0, 1'b0, 1'b0);
        tick();
        a_if.done = 1'b1;
        tick();
        a_if.done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk_a("post_abort_idle", 1'b0, 0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk("no_net_done_on_abort", 32'(nd_seen - nd_before), 32'd0);

        // Reset during ADVANCE of layer 1, then a clean pass
        a_if.start = 1'b1;
        tick();
        a_if.start = 1'b0;
        exp_launches++;
        run_layer(0, 3);
        tick();
        a_if.done = 1'b1;
        tick();
        a_if.done = 1'b0;
        chk_a("advance_l1", 1'b0, 1, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_a("reset_in_advance", 1'b0, 0, 1'b0, 1'b0, 1'b0);
        run_pass(1'b0, -1);

        // Done arriving on the 16th WAIT cycle wins over any watchdog expiry
        tick();
        a_if.start = 1'b1;
        tick();
        a_if.start = 1'b0;
        exp_launches++;
        run_layer(0, 15);
        run_layer(1, 1);
        run_layer(2, 0);

        // Done never returned on layer 0
        tick();
        a_if.start = 1'b1;
        tick();
        a_if.start = 1'b0;
        exp_launches++;
        chk_a("launch_hang", 1'b1, 0, 1'b1, 1'b0, 1'b0);
        tick();
`ifdef LAYER_SEQUENCER_WATCHDOG_EN
        for (int k = 0; k < int'(TO); k++) begin
            chk_a("wait_before_expiry", 1'b0, 0, 1'b1, 1'b0, 1'b0);
            tick();
        end
        chk_a("timeout_pulse", 1'b0, 0, 1'b0, 1'b0, 1'b1);
        tick();
        chk_a("after_timeout", 1'b0, 0, 1'b0, 1'b0, 1'b0);
`else
        for (int k = 0; k < 40; k++) begin
            chk_a("wait_forever", 1'b0, 0, 1'b1, 1'b0, 1'b0);
            tick();
        end
        a_if.abort = 1'b1;
        tick();
        a_if.abort = 1'b0;
        chk_a("abort_hang", 1'b0, 0, 1'b0, 1'b0, 1'b0);
`endif

        // Single-layer instance
        b_if.start = 1'b1;
        tick();
        b_if.start = 1'b0;
        chk_b("b_launch", 1'b1, 1'b1, 1'b0);
        tick();
        chk_b("b_wait", 1'b0, 1'b1, 1'b0);
        b_if.done = 1'b1;
        tick();
        b_if.done = 1'b0;
        chk_b("b_advance", 1'b0, 1'b1, 1'b0);
        tick();
        chk_b("b_finish", 1'b0, 1'b1, 1'b1);
        tick();
        chk_b("b_idle", 1'b0, 1'b0, 1'b0);

        tick();
        chk("total_launches", 32'(rs_seen), 32'(exp_launches));
        chk("total_net_done", 32'(nd_seen), 32'(exp_dones));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
